// File: rtl/load_store_unit_if.sv
// Pipeline request/response and RAM data-port bundle for load_store_unit.
// master = pipeline plus RAM side (the bench), slave = the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  mem_write_en;
  logic [1:0]  mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_en, mem_read_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_en, mem_read_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: one access at a time, sized RAM enables, load extension.
// Define LSU_MISALIGNED_EN to split misaligned half/word accesses into byte accesses.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | first RAM cycle (whole access, or byte 0 of a split one), or error decode
// SPLIT  | remaining single-byte accesses of a misaligned request
// RESP   | one-cycle resp_valid with result/error
module load_store_unit (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   lsu
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] res_q;
  logic        err_q;
  logic [1:0]  cnt_q, cnt_d;

  logic        is_half, is_word, legal, misaligned;
  logic [1:0]  size_code, last_idx, byte_idx;
  logic        set_err, cap_word, cap_byte;
  logic [31:0] ext_rdata;

  assign is_half    = (r_funct3[1:0] == 2'b01);
  assign is_word    = (r_funct3[1:0] == 2'b10);
  assign legal      = r_store ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = (is_half & r_addr[0]) | (is_word & (r_addr[1:0] != 2'b00));
  assign size_code  = {is_half | is_word, ~is_half};
  assign last_idx   = is_half ? 2'd1 : 2'd3;
  // cnt_q counts down the SPLIT cycles still to go; byte 0 is issued from ACCESS
  assign byte_idx   = (state_q == SPLIT) ? (last_idx - cnt_q) : 2'd0;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    lsu.req_ready    = 1'b0;
    lsu.resp_valid   = 1'b0;
    lsu.mem_write_en = 2'b00;
    lsu.mem_read_en  = 2'b00;
    lsu.mem_addr     = 32'h0;
    lsu.mem_wdata    = 32'h0;
    set_err          = 1'b0;
    cap_word         = 1'b0;
    cap_byte         = 1'b0;
    case (state_q)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (!legal) begin
          set_err = 1'b1;
          state_d = RESP;
        end else if (!misaligned) begin
          lsu.mem_addr  = r_addr;
          lsu.mem_wdata = r_wdata;
          if (r_store) lsu.mem_write_en = size_code;
          else         lsu.mem_read_en  = size_code;
          cap_word = ~r_store;
          state_d  = RESP;
        end else begin
`ifdef LSU_MISALIGNED_EN
          lsu.mem_addr  = r_addr;
          lsu.mem_wdata = r_wdata;
          if (r_store) lsu.mem_write_en = 2'b01;
          else         lsu.mem_read_en  = 2'b01;
          cap_byte = ~r_store;
          cnt_d    = last_idx - 2'd1;
          state_d  = SPLIT;
`else
          set_err = 1'b1;
          state_d = RESP;
`endif
        end
      end
      SPLIT: begin
        lsu.mem_addr  = r_addr + {30'h0, byte_idx};
        lsu.mem_wdata = r_wdata >> {byte_idx, 3'b000};
        if (r_store) lsu.mem_write_en = 2'b01;
        else         lsu.mem_read_en  = 2'b01;
        cap_byte = ~r_store;
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      RESP: begin
        lsu.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // res_q holds the raw right-justified data; extension is applied on the way out
  always_comb begin
    ext_rdata = res_q;
    case (r_funct3)
      3'b000:  ext_rdata = {{24{res_q[7]}}, res_q[7:0]};
      3'b001:  ext_rdata = {{16{res_q[15]}}, res_q[15:0]};
      3'b100:  ext_rdata = {24'h0, res_q[7:0]};
      3'b101:  ext_rdata = {16'h0, res_q[15:0]};
      default: ext_rdata = res_q;
    endcase
  end

  assign lsu.resp_rdata = (state_q == RESP) ? ext_rdata : 32'h0;
  assign lsu.resp_err   = (state_q == RESP) & err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      res_q    <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && lsu.req_valid) begin
        r_store  <= lsu.req_store;
        r_funct3 <= lsu.req_funct3;
        r_addr   <= lsu.req_addr;
        r_wdata  <= lsu.req_wdata;
        res_q    <= 32'h0;
        err_q    <= 1'b0;
      end
      if (set_err)  err_q <= 1'b1;
      if (cap_word) res_q <= lsu.mem_rdata;
      if (cap_byte) res_q[{byte_idx, 3'b000} +: 8] <= lsu.mem_rdata[7:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model predicts each response,
// a negedge monitor compares results, latency and RAM-enable cycle counts.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lsu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind the data port, and the reference model's own copy of memory
  logic [7:0] ram     [1024];
  logic [7:0] ref_mem [1024];
  logic [9:0] ra;

  assign ra = bus.mem_addr[9:0];

  always_comb begin
    bus.mem_rdata = 32'h0;
    case (bus.mem_read_en)
      2'b01: bus.mem_rdata = {24'h0, ram[ra]};
      2'b10: bus.mem_rdata = {16'h0, ram[10'(ra + 10'd1)], ram[ra]};
      2'b11: bus.mem_rdata = {ram[10'(ra + 10'd3)], ram[10'(ra + 10'd2)],
                              ram[10'(ra + 10'd1)], ram[ra]};
      default: bus.mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    case (bus.mem_write_en)
      2'b01: ram[ra] <= bus.mem_wdata[7:0];
      2'b10: begin
        ram[ra]              <= bus.mem_wdata[7:0];
        ram[10'(ra + 10'd1)] <= bus.mem_wdata[15:8];
      end
      2'b11: begin
        ram[ra]              <= bus.mem_wdata[7:0];
        ram[10'(ra + 10'd1)] <= bus.mem_wdata[15:8];
        ram[10'(ra + 10'd2)] <= bus.mem_wdata[23:16];
        ram[10'(ra + 10'd3)] <= bus.mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: access = n bytes at addr..addr+n-1, little endian
  function automatic exp_t predict(input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    bit          legal, mis, mis_en;
    logic [31:0] v;
`ifdef LSU_MISALIGNED_EN
    mis_en = 1'b1;
`else
    mis_en = 1'b0;
`endif
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (a % 32'(n)) != 0;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.lat   = 2;
    e.en    = 1;
    if (!legal || (mis && !mis_en)) begin
      e.err = 1'b1;
      e.en  = 0;
      return e;
    end
    if (mis) begin
      e.lat = n + 1;
      e.en  = n;
    end
    if (st) begin
      for (int i = 0; i < n; i++) ref_mem[10'(a + 32'(i))] = 8'(wd >> (8 * i));
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | ({24'h0, ref_mem[10'(a + 32'(i))]} << (8 * i));
      if (n < 4 && !f3[2] && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      e.rdata = v;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold, input bit use_fix,
                      input logic [31:0] fix_rdata, input logic fix_err, output int acc_cyc);
    exp_t e;
    int   waited;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    waited  = 0;
    acc_cyc = -1;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready expected=ready (cycle %0d)", cyc);
    end else begin
      e = predict(st, f3, a, wd);
      if (use_fix) begin
        e.rdata = fix_rdata;
        e.err   = fix_err;
      end
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Monitor: accepts, enable cycles and responses, all sampled on the falling edge
  initial begin
    exp_t e;
    int   en_cnt;
    int   lat;
    en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
        en_cnt = 0;
      end else begin
        if (bus.mem_write_en != 2'b00 || bus.mem_read_en != 2'b00) en_cnt++;
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=resp_valid expected=none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("enable_cycles", 32'(en_cnt), 32'(e.en));
            lat = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1;
            chk("latency", 32'(lat), 32'(e.lat));
          end
          en_cnt = 0;
        end
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_tab [10];
    logic [31:0] tmp;
    int          acc, prev_acc, bad;
    exp_t        dummy;

    checks = 0;
    errors = 0;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 1024; i++) begin
      tmp        = $urandom;
      ram[i]     <= tmp[7:0];
      ref_mem[i] = tmp[7:0];
    end
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_mem_en", {28'h0, bus.mem_write_en, bus.mem_read_en}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence around 0xF0
    send(1'b1, 3'b010, 32'hF0, 32'h8000FF11, 1'b0, 1'b1, 32'h0, 1'b0, acc);
    send(1'b0, 3'b000, 32'hF0, 32'h0, 1'b0, 1'b1, 32'h00000011, 1'b0, acc);
    send(1'b0, 3'b001, 32'hF2, 32'h0, 1'b0, 1'b1, 32'hFFFF8000, 1'b0, acc);
    send(1'b0, 3'b101, 32'hF2, 32'h0, 1'b0, 1'b1, 32'h00008000, 1'b0, acc);
    send(1'b0, 3'b010, 32'hF0, 32'h0, 1'b0, 1'b1, 32'h8000FF11, 1'b0, acc);
    send(1'b1, 3'b100, 32'hF0, 32'h12345678, 1'b0, 1'b1, 32'h0, 1'b1, acc);
    send(1'b0, 3'b010, 32'hF0, 32'h0, 1'b0, 1'b1, 32'h8000FF11, 1'b0, acc);
    send(1'b0, 3'b010, 32'hF1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    drain();

    // Randomized traffic in a small window so loads revisit stored bytes
    for (int k = 0; k < 80; k++) begin
      send(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)],
           32'h100 + 32'($urandom_range(0, 47)), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // req_valid held high: aligned accesses accepted every third cycle
    prev_acc = -1;
    for (int k = 0; k < 8; k++) begin
      send(1'($urandom_range(0, 1)), 3'b010, 32'h140 + 32'(4 * k), $urandom,
           1'b1, 1'b0, 32'h0, 1'b0, acc);
      if (prev_acc >= 0) chk("accept_spacing", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    bus.req_valid = 1'b0;
    drain();

    // Reset during ACCESS of a load: no response, reset values next cycle
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_ready", 32'(bus.req_ready), 32'h1);
    chk("abort_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    chk("abort_rdata", bus.resp_rdata, 32'h0);
    chk("abort_mem_en", {28'h0, bus.mem_write_en, bus.mem_read_en}, 32'h0);
    chk("abort_mem_addr", bus.mem_addr, 32'h0);
    chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Store whose access cycle meets the reset edge still lands in RAM
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h108;
    bus.req_wdata  = $urandom;
    @(posedge clk); #1;
    dummy         = predict(1'b1, 3'b010, 32'h108, bus.req_wdata);
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    send(1'b0, 3'b010, 32'h108, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    drain();

    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image_bad_bytes", 32'(bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port req_valid, input, 1, pipeline presents an access.
REQ-004 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-005 SHALL have port req_store, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3, RISC-V funct3 size/sign code.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, extended load result.
REQ-011 SHALL have port resp_err, output, 1, access rejected.
REQ-012 SHALL have port mem_write_en, output, 2, RAM write size: 00 off, 01 byte, 10 half, 11 word.
REQ-013 SHALL have port mem_read_en, output, 2, RAM read size, same encoding.
REQ-014 SHALL have ports mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32), the RAM data-port address, write data and combinational read data; RAM handles byte lanes from mem_addr[1:0], right-justifying reads and taking write data from the low bits.

Function
REQ-015 SHALL decode funct3 as follows: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores accept 000/001/010 only.
REQ-016 SHALL implement FSM states IDLE, ACCESS, SPLIT and RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL, in IDLE, on req_valid & req_ready, register the request and go to ACCESS; with no valid request it SHALL stay in IDLE.
REQ-018 SHALL, in ACCESS with an aligned legal request, drive mem_addr = req_addr and mem_wdata = req_wdata, set the size code on mem_write_en (store) or mem_read_en (load), capture mem_rdata at the end of that cycle, and go to RESP.
REQ-019 SHALL keep mem_write_en = mem_read_en = 00 in every state other than the access cycles.
REQ-020 SHALL, in RESP, assert resp_valid for exactly one cycle with resp_rdata and resp_err held, then return to IDLE; accept-to-resp_valid latency is 2 cycles for aligned accesses.
REQ-021 SHALL extend load results: signed byte/half sign-extended from bit 7/15, unsigned zero-extended; resp_rdata = 0 for stores and errors.
REQ-022 SHALL treat an illegal funct3 as an error: no RAM enable, resp_err = 1 in RESP.
REQ-023 SHALL define misaligned as a half with addr[0] = 1, or a word with addr[1:0] != 00.

Reset
REQ-024 SHALL, on a reset edge, force IDLE and drive req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem enables 00, mem_addr = 0 and mem_wdata = 0.
REQ-025 SHALL, on reset mid-operation, abandon the request without a response; a store whose access cycle coincides with the reset edge commits in RAM.

Configuration
REQ-026 SHALL, when LSU_MISALIGNED_EN is defined, route misaligned accesses from ACCESS to SPLIT, which issues n single-byte accesses (n = 2 half, 4 word) at req_addr + i, i = 0..n-1, one per cycle.
REQ-027 SHALL, in SPLIT, drive mem_wdata = req_wdata >> 8i for stores and place mem_rdata[7:0] into result bits [8i+7:8i] for loads, then extend per REQ-021 and go to RESP; latency is n + 1 cycles.
REQ-028 SHALL, when LSU_MISALIGNED_EN is undefined, go from ACCESS directly to RESP on a misaligned access with no RAM enable and resp_err = 1; SPLIT is unreachable.
REQ-029 SHALL never set resp_err for misalignment when LSU_MISALIGNED_EN is defined.

Verification
REQ-030 SHALL cover: store word, funct3 010, addr 0xF0, data 0x8000FF11, then load byte signed (funct3 000) at 0xF0 -> resp_rdata 0x00000011 two cycles after accept; load half signed (funct3 001) at 0xF2 -> 0xFFFF8000.
REQ-031 SHALL cover: load half unsigned (funct3 101) at 0xF2 -> 0x00008000; load word at 0xF0 -> 0x8000FF11, resp_err 0.
REQ-032 SHALL cover: store with funct3 100 -> resp_err 1, mem_write_en 00 in every cycle, RAM word unchanged.
REQ-033 SHALL cover: load word at 0xF1 -> without LSU_MISALIGNED_EN resp_err 1 after 2 cycles; with it, four byte reads 0xF1..0xF4, resp_valid 5 cycles after accept, bytes assembled in address order.
REQ-034 SHALL cover: rst_n low during ACCESS of a load -> no resp_valid, next cycle req_ready 1 and all outputs at reset values.
REQ-035 SHALL cover: req_valid held high continuously -> one accept per 3 cycles, req_ready 0 in ACCESS and RESP.
